// File: rtl/sampling_pkg.sv
// Constants shared by the downsampler/upsampler pair: default raster size,
// counter width and pixel width.
package sampling_pkg;
    localparam int NUMCOL_DEF = 800;
    localparam int NUMROW_DEF = 600;
    localparam int CNT_W      = 10;
    localparam int DW_DEF     = 8;

    typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/downsampler2_if.sv
// Pixel stream in, averaged pixel stream out to the external FIFO, plus raster
// position and status.
interface downsampler2_if #(
    parameter int DW = sampling_pkg::DW_DEF
);
    logic                           valid;
    logic [DW-1:0]                  data;
    logic                           fifo_full;
    logic [sampling_pkg::CNT_W-1:0] current_rowcount;
    logic [sampling_pkg::CNT_W-1:0] current_colcount;
    logic [DW-1:0]                  dataout;
    logic                           validout;
    logic                           frame_done;
    logic                           overflow;

    modport slave (
        input  valid, data, fifo_full,
        output current_rowcount, current_colcount, dataout, validout, frame_done, overflow
    );

    modport master (
        output valid, data, fifo_full,
        input  current_rowcount, current_colcount, dataout, validout, frame_done, overflow
    );
endinterface

// File: rtl/line_buffer_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port whose output
// holds while re is low.
module line_buffer_ram #(
    parameter int DEPTH = 400,
    parameter int WIDTH = 9,
    parameter int AW    = 9
) (
    input  logic             clock,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
    end

    // q must survive input gaps between the two pixels that consume it.
    always_ff @(posedge clock) begin
        if (re) q <= mem[raddr];
    end
endmodule

// File: rtl/downsampler2.sv
// 2x2 box-average decimator: even rows store horizontal pair sums in a line
// buffer, odd rows add the stored sum to the current pair and emit sum/4.
module downsampler2
    import sampling_pkg::*;
#(
    parameter int NUMCOL = NUMCOL_DEF,
    parameter int NUMROW = NUMROW_DEF,
    parameter int DW     = DW_DEF
) (
    input  logic          clock,
    input  logic          reset,
    downsampler2_if.slave bus
);
    localparam int   AW       = (NUMCOL / 2 > 1) ? $clog2(NUMCOL / 2) : 1;
    localparam cnt_t LAST_COL = cnt_t'(NUMCOL - 1);
    localparam cnt_t LAST_ROW = cnt_t'(NUMROW - 1);

    cnt_t          row, col;
    logic [DW-1:0] h_reg;
    logic [DW:0]   pair_sum, lb_q;
    logic [DW+1:0] sum4;
    logic [AW-1:0] lb_addr;
    logic          odd_row, odd_col, last_col, last_row;
    logic          lb_we, lb_re, fire;
    logic [DW-1:0] dataout;
    logic          validout, frame_done, overflow;

    assign odd_row  = row[0];
    assign odd_col  = col[0];
    assign last_col = (col == LAST_COL);
    assign last_row = (row == LAST_ROW);
    assign lb_addr  = col[AW:1];

    assign pair_sum = {1'b0, h_reg} + {1'b0, bus.data};
    assign sum4     = {1'b0, lb_q} + {2'b00, h_reg} + {2'b00, bus.data};

    assign lb_we = bus.valid && !odd_row && odd_col;
    assign lb_re = bus.valid && odd_row && !odd_col;
    assign fire  = bus.valid && odd_row && odd_col;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            row <= '0;
            col <= '0;
        end else if (bus.valid) begin
            if (last_col) begin
                col <= '0;
                row <= last_row ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                  h_reg <= '0;
        else if (bus.valid && !odd_col) h_reg <= bus.data;
    end

    line_buffer_ram #(
        .DEPTH(NUMCOL / 2),
        .WIDTH(DW + 1),
        .AW   (AW)
    ) u_line_buffer (
        .clock(clock),
        .we   (lb_we),
        .waddr(lb_addr),
        .wdata(pair_sum),
        .re   (lb_re),
        .raddr(lb_addr),
        .q    (lb_q)
    );

    // The FIFO cannot stall us; a write into a full FIFO is only flagged.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dataout    <= '0;
            validout   <= 1'b0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            validout   <= fire;
            frame_done <= fire && last_row && last_col;
            overflow   <= overflow || (validout && bus.fifo_full);
            if (fire) dataout <= sum4[DW+1:2];
        end
    end

    assign bus.current_rowcount = row;
    assign bus.current_colcount = col;
    assign bus.dataout          = dataout;
    assign bus.validout         = validout;
    assign bus.frame_done       = frame_done;
    assign bus.overflow         = overflow;
endmodule
